// File: rtl/nz_brick_encoder_pkg.sv
// nz_brick_encoder_pkg: shared state encodings and lane-offset width helper
package nz_brick_encoder_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  function automatic int off_w(input int lanes);
    return $clog2(lanes);
  endfunction
endpackage

// File: rtl/nz_brick_encoder_if.sv
// nz_brick_encoder_if: brick-in / beat-out handshake bundle
interface nz_brick_encoder_if
  import nz_brick_encoder_pkg::*;
#(
  parameter int N = 16,
  parameter int LANES = 16,
  parameter int ADDR_SIZE = 16,
  localparam int OFF_W = off_w(LANES)
);
  logic in_valid;
  logic in_ready;
  logic [LANES*N-1:0] in_data;
  logic [ADDR_SIZE-1:0] base_addr;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] out_data;
  logic [OFF_W-1:0] out_offset;
  logic [ADDR_SIZE-1:0] out_addr;
  logic out_last;
  logic out_empty;
  modport master (
    output in_valid, in_data, base_addr, out_ready,
    input in_ready, out_valid, out_data, out_offset, out_addr, out_last, out_empty
  );
  modport slave (
    input in_valid, in_data, base_addr, out_ready,
    output in_ready, out_valid, out_data, out_offset, out_addr, out_last, out_empty
  );
endinterface

// File: rtl/nz_brick_encoder_lsb_onehot_enc.sv
// lsb_onehot_enc: isolates the lowest set bit of vec and encodes its index
module lsb_onehot_enc
  import nz_brick_encoder_pkg::*;
#(
  parameter int LANES = 16,
  localparam int OFF_W = off_w(LANES)
) (
  input  logic [LANES-1:0] vec,
  output logic [LANES-1:0] onehot,
  output logic [OFF_W-1:0] idx,
  output logic             valid
);
  assign onehot = vec & (~vec + LANES'(1));
  assign valid = |vec;
  always_comb begin
    idx = '0;
    for (int i = 0; i < LANES; i++) idx |= onehot[i] ? OFF_W'(i) : '0;
  end
endmodule

// File: rtl/nz_brick_encoder.sv
// nz_brick_encoder: zero-skipping brick encoder, one beat per non-zero lane
module nz_brick_encoder
  import nz_brick_encoder_pkg::*;
#(
  parameter int N = 16,
  parameter int LANES = 16,
  parameter int ADDR_SIZE = 16,
  localparam int OFF_W = off_w(LANES)
) (
  input logic clk,
  input logic rst,
  nz_brick_encoder_if.slave bus
);
  logic [0:0] state;
  logic [LANES*N-1:0] brick;
  logic [LANES-1:0] mask, onehot, in_mask;
  logic [ADDR_SIZE-1:0] base;
  logic [OFF_W-1:0] off;
  logic any, emit, last, beat, done, accept;
  lsb_onehot_enc #(.LANES(LANES)) u_enc (.vec(mask), .onehot(onehot), .idx(off), .valid(any));
  for (genvar l = 0; l < LANES; l++) assign in_mask[l] = |bus.in_data[l*N +: N];
  // an empty mask while in EMIT is the single empty-brick beat, which is also last
  assign emit = state == EMIT;
  assign last = (mask & (mask - LANES'(1))) == '0;
  assign beat = emit && bus.out_ready;
  assign done = beat && last;
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.in_ready = !emit || done;
  assign bus.out_valid = emit;
  assign bus.out_last = emit && last;
  assign bus.out_empty = emit && !any;
  assign bus.out_offset = emit ? off : '0;
  assign bus.out_data = emit ? brick[off*N +: N] : '0;
  assign bus.out_addr = emit ? base + ADDR_SIZE'(off) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      brick <= '0;
      mask <= '0;
      base <= '0;
    end else if (accept) begin
      state <= EMIT;
      brick <= bus.in_data;
      mask <= in_mask;
      base <= bus.base_addr;
    end else if (beat) begin
      state <= done ? IDLE : EMIT;
      mask <= mask & ~onehot;
    end
endmodule

// File: tb/tb_nz_brick_encoder.sv
// tb_nz_brick_encoder: directed checks of beats, wrap, back-pressure, reset and streaming
module tb_nz_brick_encoder;
  localparam int N = 16, LANES = 16, AW = 16;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0, hs = 0;
  nz_brick_encoder_if #(.N(N), .LANES(LANES), .ADDR_SIZE(AW)) bus ();
  nz_brick_encoder #(.N(N), .LANES(LANES), .ADDR_SIZE(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.out_valid && bus.out_ready) hs++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input string tag, input logic [15:0] d, input logic [3:0] o,
                      input logic [15:0] a, input logic l, input logic e);
    chk({tag, ".valid"}, 32'(bus.out_valid), 1);
    chk({tag, ".data"}, 32'(bus.out_data), 32'(d));
    chk({tag, ".off"}, 32'(bus.out_offset), 32'(o));
    chk({tag, ".addr"}, 32'(bus.out_addr), 32'(a));
    chk({tag, ".last"}, 32'(bus.out_last), 32'(l));
    chk({tag, ".empty"}, 32'(bus.out_empty), 32'(e));
  endtask

  task automatic present(input logic [LANES*N-1:0] d, input logic [15:0] b);
    int w;
    bus.in_valid = 1;
    bus.in_data = d;
    bus.base_addr = b;
    #1;
    for (w = 0; w < 20 && !bus.in_ready; w++) step();
    if (!bus.in_ready) chk("in_ready_wait", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.in_data = '1;
    bus.base_addr = 16'hDEAD;
    #1;
  endtask

  logic [LANES*N-1:0] b3, bz, bw;
  logic [LANES*N-1:0] sd [4];
  logic [15:0] sb [4];
  logic [15:0] ed [7], ea [7];
  logic [3:0] eo [7];
  logic el [7];

  initial begin
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.base_addr = '0;
    bus.out_ready = 1;
    b3 = '0; b3[3*N +: N] = 16'h0005; b3[9*N +: N] = 16'h00A0; b3[15*N +: N] = 16'hFFFF;
    bz = '0;
    bw = '0; bw[5*N +: N] = 16'h0001;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 0);
    chk("rst.in_ready", 32'(bus.in_ready), 1);
    chk("rst.out_data", 32'(bus.out_data), 0);
    chk("rst.out_addr", 32'(bus.out_addr), 0);
    chk("rst.last_empty", 32'({bus.out_last, bus.out_empty}), 0);

    present(b3, 16'h0100);
    beat("b3.0", 16'h0005, 3, 16'h0103, 0, 0);
    chk("b3.in_ready_mid", 32'(bus.in_ready), 0);
    step();
    beat("b3.1", 16'h00A0, 9, 16'h0109, 0, 0);
    step();
    beat("b3.2", 16'hFFFF, 15, 16'h010F, 1, 0);
    chk("b3.in_ready_last", 32'(bus.in_ready), 1);
    step();
    chk("b3.idle", 32'(bus.out_valid), 0);

    present(bz, 16'h2000);
    beat("zero", 16'h0000, 0, 16'h2000, 1, 1);
    step();
    chk("zero.idle", 32'(bus.out_valid), 0);

    present(bw, 16'hFFFE);
    beat("wrap", 16'h0001, 5, 16'h0003, 1, 0);
    step();

    bus.out_ready = 0;
    present(b3, 16'h0100);
    beat("rst_mid", 16'h0005, 3, 16'h0103, 0, 0);
    rst = 1;
    #1;
    chk("rst_mid.out_valid", 32'(bus.out_valid), 0);
    chk("rst_mid.in_ready", 32'(bus.in_ready), 1);
    chk("rst_mid.out_data", 32'(bus.out_data), 0);
    @(posedge clk);
    #1 rst = 0;
    bus.out_ready = 1;
    repeat (2) step();
    chk("rst_mid.no_stale", 32'(bus.out_valid), 0);

    hs = 0;
    present(b3, 16'h0100);
    beat("bp.c1", 16'h0005, 3, 16'h0103, 0, 0);
    step();
    bus.out_ready = 0;
    #1;
    beat("bp.c2", 16'h00A0, 9, 16'h0109, 0, 0);
    chk("bp.in_ready", 32'(bus.in_ready), 0);
    step();
    beat("bp.c3", 16'h00A0, 9, 16'h0109, 0, 0);
    step();
    bus.out_ready = 1;
    #1;
    beat("bp.c4", 16'h00A0, 9, 16'h0109, 0, 0);
    step();
    beat("bp.c5", 16'hFFFF, 15, 16'h010F, 1, 0);
    step();
    chk("bp.idle", 32'(bus.out_valid), 0);
    chk("bp.handshakes", 32'(hs), 3);

    sd[0] = '0; sd[0][0*N +: N] = 16'h0011; sd[0][7*N +: N] = 16'h0022; sb[0] = 16'h0000;
    sd[1] = '0; sb[1] = 16'h0040;
    sd[2] = '0; sd[2][15*N +: N] = 16'h0033; sb[2] = 16'h1000;
    sd[3] = '0; sd[3][1*N +: N] = 16'h0044; sd[3][2*N +: N] = 16'h0055; sd[3][14*N +: N] = 16'h0066;
    sb[3] = 16'h0200;
    ed = '{16'h0011, 16'h0022, 16'h0000, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
    eo = '{4'd0, 4'd7, 4'd0, 4'd15, 4'd1, 4'd2, 4'd14};
    ea = '{16'h0000, 16'h0007, 16'h0040, 16'h100F, 16'h0201, 16'h0202, 16'h020E};
    el = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    begin
      int b, nb, first, lastc;
      logic acc;
      b = 0; nb = 0; first = -1; lastc = -1;
      for (int c = 0; c < 30; c++) begin
        bus.in_valid = b < 4;
        if (b < 4) begin
          bus.in_data = sd[b];
          bus.base_addr = sb[b];
        end
        #1;
        if (bus.out_valid) begin
          if (nb < 7) begin
            chk($sformatf("st%0d.data", nb), 32'(bus.out_data), 32'(ed[nb]));
            chk($sformatf("st%0d.off", nb), 32'(bus.out_offset), 32'(eo[nb]));
            chk($sformatf("st%0d.addr", nb), 32'(bus.out_addr), 32'(ea[nb]));
            chk($sformatf("st%0d.last", nb), 32'(bus.out_last), 32'(el[nb]));
          end
          nb++;
          if (first < 0) first = c;
          lastc = c;
        end
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        if (acc) b++;
      end
      chk("st.bricks", 32'(b), 4);
      chk("st.beats", 32'(nb), 7);
      chk("st.span", 32'(lastc - first + 1), 7);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
